// File: rtl/sd_access_arbiter.sv
// rtl/sd_access_arbiter.sv - SD port sequencer/arbiter between a sector reader and a sector writer
// Optional abort watchdog enabled by defining SD_ARB_WATCHDOG_EN.
module sd_access_arbiter #(
  parameter logic [23:0] WDOG_CYCLES = 24'd8_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        rd_ack,
  output logic        rd_done,
  input  logic        wr_req,
  input  logic [31:0] wr_sector,
  output logic        wr_ack,
  output logic        wr_done,
  output logic        err,
  output logic        eng_rstart,
  input  logic        eng_rdone,
  input  logic        eng_rbusy,
  output logic        eng_wstart,
  input  logic        eng_wdone,
  input  logic        eng_wbusy,
  output logic [31:0] eng_sector,
  output logic [1:0]  owner,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GRANT, WAIT_BUSY, RUN, RELEASE} state_t;

  state_t state;
  logic   last_wr;
  logic   pick_wr;
  logic   own_done;
  logic   own_busy;
  logic   timeout;
  logic   waiting;

  // Ties go to whichever side was not served last.
  assign pick_wr  = wr_req && (!rd_req || !last_wr);
  assign own_done = owner[1] ? eng_wdone : eng_rdone;
  assign own_busy = owner[1] ? eng_wbusy : eng_rbusy;
  assign waiting  = (state == WAIT_BUSY) || (state == RUN);

`ifdef SD_ARB_WATCHDOG_EN
  logic [23:0] wdog;
  logic        err_q;

  // Counts cycles since the start pulse; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      wdog <= 24'd0;
    end else if (state != RELEASE && wdog != 24'hFF_FFFF) begin
      wdog <= wdog + 24'd1;
    end
  end

  assign timeout = waiting && (wdog == WDOG_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout && !own_done;
    end
  end

  assign err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign timeout     = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_wr    <= 1'b1;
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      eng_rstart <= 1'b0;
      eng_wstart <= 1'b0;
      eng_sector <= 32'd0;
      owner      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      eng_rstart <= 1'b0;
      eng_wstart <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req || wr_req) begin
            state      <= GRANT;
            busy       <= 1'b1;
            last_wr    <= pick_wr;
            owner      <= pick_wr ? 2'b10 : 2'b01;
            eng_sector <= pick_wr ? wr_sector : rd_sector;
            rd_ack     <= !pick_wr;
            wr_ack     <= pick_wr;
            eng_rstart <= !pick_wr;
            eng_wstart <= pick_wr;
          end
        end
        GRANT: state <= WAIT_BUSY;
        WAIT_BUSY, RUN: begin
          if (own_done || timeout) begin
            state   <= RELEASE;
            rd_done <= !owner[1];
            wr_done <= owner[1];
          end else if (state == WAIT_BUSY && own_busy) begin
            state <= RUN;
          end
        end
        RELEASE: begin
          // Owner drops for one idle cycle so pin directions can turn around.
          state <= IDLE;
          owner <= 2'b00;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_access_arbiter.sv
// tb/tb_sd_access_arbiter.sv - directed self-checking bench for sd_access_arbiter
module tb_sd_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [31:0] rd_sector, wr_sector;
  logic        rd_ack, rd_done, wr_ack, wr_done, err;
  logic        eng_rstart, eng_rdone, eng_rbusy;
  logic        eng_wstart, eng_wdone, eng_wbusy;
  logic [31:0] eng_sector;
  logic [1:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int seen;

  sd_access_arbiter #(.WDOG_CYCLES(24'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_sector(rd_sector), .rd_ack(rd_ack), .rd_done(rd_done),
    .wr_req(wr_req), .wr_sector(wr_sector), .wr_ack(wr_ack), .wr_done(wr_done),
    .err(err),
    .eng_rstart(eng_rstart), .eng_rdone(eng_rdone), .eng_rbusy(eng_rbusy),
    .eng_wstart(eng_wstart), .eng_wdone(eng_wdone), .eng_wbusy(eng_wbusy),
    .eng_sector(eng_sector), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs every pulse/level output for a compact all-quiet comparison.
  function automatic logic [31:0] outs();
    return {20'd0, rd_ack, wr_ack, rd_done, wr_done, err,
            eng_rstart, eng_wstart, busy, owner, 2'b00};
  endfunction

  initial begin
    rst_n = 1'b0; rd_req = 0; wr_req = 0; rd_sector = 0; wr_sector = 0;
    eng_rdone = 0; eng_rbusy = 0; eng_wdone = 0; eng_wbusy = 0;
    tick(); tick();
    check("reset_outs", outs(), 32'd0);
    check("reset_sector", eng_sector, 32'd0);
    rst_n = 1'b1;
    tick();

    // First tie after reset: read wins, write follows after RELEASE.
    rd_req = 1; wr_req = 1; rd_sector = 32'hAAAA_0001; wr_sector = 32'hBBBB_0002;
    tick();
    check("tie1_rd_ack", {rd_ack, wr_ack, eng_rstart, eng_wstart}, 32'b1010);
    check("tie1_owner", owner, 32'd1);
    check("tie1_sector", eng_sector, 32'hAAAA_0001);
    rd_req = 0;
    tick();
    check("tie1_ack_pulse", {rd_ack, eng_rstart}, 32'd0);
    eng_rdone = 1;
    tick();
    eng_rdone = 0;
    check("tie1_rd_done", {rd_done, wr_done, err}, 32'b100);
    check("tie1_owner_held", owner, 32'd1);
    tick();
    check("tie1_release", {owner, wr_ack, busy}, 32'd0);
    tick();
    check("tie1_wr_ack", {rd_ack, wr_ack, eng_rstart, eng_wstart}, 32'b0101);
    check("tie1_wr_owner", owner, 32'd2);
    check("tie1_wr_sector", eng_sector, 32'hBBBB_0002);
    wr_req = 0;
    tick();
    eng_wdone = 1;
    tick();
    eng_wdone = 0;
    check("tie1_wr_done", {rd_done, wr_done}, 32'b01);
    tick(); tick();

    // Plain read with busy then done.
    rd_req = 1; rd_sector = 32'h0000_1234;
    tick();
    check("rd_grant", {rd_ack, eng_rstart, busy}, 32'b111);
    check("rd_owner", owner, 32'd1);
    check("rd_sector", eng_sector, 32'h0000_1234);
    rd_req = 0;
    tick();
    eng_rbusy = 1;
    tick(); tick(); tick();
    check("rd_running", {rd_done, owner, busy}, 32'b0011);
    eng_rbusy = 0; eng_rdone = 1;
    tick();
    eng_rdone = 0;
    check("rd_done", {rd_done, owner}, 32'b101);
    tick();
    check("rd_released", {rd_done, owner, busy}, 32'd0);
    check("rd_sector_kept", eng_sector, 32'h0000_1234);
    tick();

    // Second tie (read served last): write first.
    rd_req = 1; wr_req = 1; rd_sector = 32'h0000_0077; wr_sector = 32'h0000_0099;
    tick();
    check("tie2_wr_first", {rd_ack, wr_ack}, 32'b01);
    check("tie2_sector", eng_sector, 32'h0000_0099);
    wr_req = 0;
    tick();
    // Reader pulses while the writer owns the bus.
    eng_rdone = 1; eng_rbusy = 1;
    tick();
    eng_rdone = 0; eng_rbusy = 0;
    check("spurious_ignored", {rd_done, wr_done, rd_ack, owner}, 32'b00010);
    tick();
    check("spurious_still_wait", {rd_done, wr_done, owner}, 32'b0010);
    // Busy and done together in WAIT_BUSY.
    eng_wbusy = 1; eng_wdone = 1;
    tick();
    eng_wbusy = 0; eng_wdone = 0;
    check("same_cycle_done", {rd_done, wr_done}, 32'b01);
    tick();
    check("no_dup_done", {wr_done, owner, rd_ack}, 32'd0);
    tick();
    check("tie2_rd_after", {rd_ack, wr_ack}, 32'b10);
    check("tie2_rd_sector", eng_sector, 32'h0000_0077);
    rd_req = 0;
    tick();
    eng_rdone = 1;
    tick();
    eng_rdone = 0;
    check("tie2_rd_done", rd_done, 32'd1);
    tick(); tick();

    // Engine never completes: watchdog build aborts 100 cycles after start.
    wr_req = 1; wr_sector = 32'h0000_0500;
    tick();
    check("wd_grant", {wr_ack, eng_wstart}, 32'b11);
    wr_req = 0;
    seen = 0;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (wr_done || err) seen++;
    end
    check("wd_early_done", seen, 32'd0);
    tick();
`ifdef SD_ARB_WATCHDOG_EN
    check("wd_abort", {wr_done, err}, 32'b11);
    tick();
    check("wd_owner_free", {owner, err, wr_done}, 32'd0);
    tick();
`else
    check("wd_no_abort", {wr_done, err, owner}, 32'b0010);
    tick();
    check("wd_still_wait", {busy, owner, err}, 32'b1100);
    eng_wdone = 1;
    tick();
    eng_wdone = 0;
    check("wd_manual_done", {wr_done, err}, 32'b10);
    tick(); tick();
`endif

    // Reset during RUN.
    rd_req = 1; rd_sector = 32'h0000_0ABC;
    tick();
    check("rr_grant", rd_ack, 32'd1);
    rd_req = 0;
    tick();
    eng_rbusy = 1;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1; eng_rbusy = 0;
    check("rr_outs", outs(), 32'd0);
    check("rr_sector", eng_sector, 32'd0);
    rd_req = 1; rd_sector = 32'h0000_0005;
    tick();
    check("rr_regrant", {rd_ack, owner}, 32'b101);
    check("rr_regrant_sector", eng_sector, 32'h0000_0005);
    rd_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sd_access_arbiter.md
# sd_access_arbiter

Sequencer/arbiter sharing the single SD card port between one sector-read requester and one sector-write requester. Accepts one request at a time via req/ack, issues a one-cycle start pulse with the sector number to the matching engine (sector writer or reader), tracks it to completion, and drives an ownership code used by the top level to mux SD clock/CMD/DAT and the board direction pins. Sits between the user/cache logic and the SD reader/writer engines.

## Interface
- WDOG_CYCLES, 24'd8_000_000, clk cycles allowed from start pulse to engine done before abort (watchdog build only)
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rd_req  in  1  read request; held high until rd_ack
- rd_sector  in  32  read sector number; stable while rd_req high
- rd_ack  out  1  one-cycle pulse: read request accepted
- rd_done  out  1  one-cycle pulse: read finished
- wr_req  in  1  write request; held high until wr_ack
- wr_sector  in  32  write sector number; stable while wr_req high
- wr_ack  out  1  one-cycle pulse: write request accepted
- wr_done  out  1  one-cycle pulse: write finished
- err  out  1  one-cycle pulse alongside rd_done/wr_done when the operation was aborted by watchdog
- eng_rstart  out  1  start pulse to reader engine
- eng_rdone  in  1  reader done pulse
- eng_rbusy  in  1  reader busy
- eng_wstart  out  1  start pulse to writer engine
- eng_wdone  in  1  writer done pulse
- eng_wbusy  in  1  writer busy
- eng_sector  out  32  sector number to both engines, registered
- owner  out  2  00 none, 01 reader, 10 writer; 11 never driven
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, GRANT, WAIT_BUSY, RUN, RELEASE.
- IDLE: owner=00. If any req high → GRANT next cycle. Both high → grant the requester not served last (last_rw flag, reset to "write" so read wins first tie). One high → that one.
- GRANT (exactly 1 cycle): owner set, eng_sector latched from the granted *_sector, matching *_ack=1 and eng_*start=1; last_rw updated → WAIT_BUSY.
- WAIT_BUSY: wait for owning engine busy=1 → RUN. If owning engine done=1 arrives first (or same cycle as busy) → completion directly.
- RUN: wait for owning engine done pulse → completion.
- Completion: *_done pulse for owning requester in the cycle after engine done; → RELEASE.
- RELEASE (exactly 1 cycle): owner=00 (pin turnaround gap), → IDLE. New grant earliest 1 cycle later.
- Done/busy of the non-owning engine ignored in every state.
- Requests arriving during non-IDLE states are held pending by the requester (level protocol); no queueing inside block.

## Timing
- Reset values: rd_ack, wr_ack, rd_done, wr_done, err, eng_rstart, eng_wstart, busy = 0; owner=00; eng_sector=0; state IDLE; last_rw=write.
- Reset mid-operation: all outputs to reset values next edge; engine state not touched (engines reset separately).
- req at edge N sampled in IDLE → ack/start/owner visible after edge N+1.
- eng done at edge M → *_done after edge M+1; owner=00 after edge M+2; next ack earliest after edge M+3.
- Minimum request-to-request spacing: 4 cycles + engine latency.
- eng_sector constant from GRANT until next GRANT.

## Configuration
- SD_ARB_WATCHDOG_EN defined: 24-bit counter cleared in GRANT, increments in WAIT_BUSY and RUN; reaching WDOG_CYCLES-1 forces completion with err=1 and *_done=1 same cycle, then RELEASE; counter saturates, never wraps.
- Not defined: no counter, WAIT_BUSY/RUN wait indefinitely, err tied 0, WDOG_CYCLES unused.

## Test plan
- Reset then rd_req=1, rd_sector=32'h0000_1234 → rd_ack and eng_rstart pulse 1 cycle, eng_sector=32'h1234, owner=01; engine busy then done → rd_done 1 cycle later, owner=00 next, busy=0 after.
- rd_req and wr_req raised same cycle → read granted first, write granted after read's RELEASE; second tie after that grants write first.
- Engine pulses done in same cycle as busy rises in WAIT_BUSY → single *_done, no hang, no duplicate done.
- Writer owns bus; spurious eng_rdone and eng_rbusy pulses → ignored, owner stays 10, no rd_done.
- With SD_ARB_WATCHDOG_EN, WDOG_CYCLES=100, engine never completes → wr_done and err pulse exactly 100 cycles after start, owner=00 next cycle; without macro same stimulus → stays in WAIT_BUSY, err never asserts.
- rst_n low for 1 cycle during RUN → all outputs at reset values next edge; subsequent rd_req granted normally.
